// File: rtl/dlx_mem_pkg.sv
// Shared types and helpers for the DLX MEM stage: access sizes, wait FSM states
// and the natural-alignment test.
package dlx_mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic {IDLE, WAIT} mem_state_e;

  // Doublewords only exist on a 64-bit datapath; elsewhere they can never align.
  function automatic logic is_aligned(input size_e sz, input logic [2:0] addr_lo,
                                      input logic xlen64);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return addr_lo[0] == 1'b0;
      SZ_W:    return addr_lo[1:0] == 2'b00;
      default: return xlen64 && (addr_lo == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the MEM stage: byte enables, store replication and
// load extraction with sign/zero extension. Purely combinational.
module mem_lane_align
  import dlx_mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]   off,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_raw,
  input  logic            load_unsigned,
  output logic [NB-1:0]   byte_en,
  output logic [XLEN-1:0] store_rep,
  output logic [XLEN-1:0] load_ext
);

  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                  input size_e sz, input logic uns);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    b_s = raw[7:0];
    h_s = raw[15:0];
    w_s = raw[31:0];
    case (sz)
      SZ_B:    return uns ? XLEN'(raw[7:0])  : XLEN'(b_s);
      SZ_H:    return uns ? XLEN'(raw[15:0]) : XLEN'(h_s);
      SZ_W:    return uns ? XLEN'(raw[31:0]) : XLEN'(w_s);
      default: return raw;
    endcase
  endfunction

  logic [NB-1:0]   mask;
  logic [XLEN-1:0] shifted;

  always_comb begin
    mask = '0;
    store_rep = store_data;
    case (size_e'(size))
      SZ_B: begin
        mask = NB'(1);
        store_rep = {NB{store_data[7:0]}};
      end
      SZ_H: begin
        mask = NB'(3);
        store_rep = {(NB/2){store_data[15:0]}};
      end
      SZ_W: begin
        mask = NB'(15);
        store_rep = {(NB/4){store_data[31:0]}};
      end
      default: begin
        mask = '1;
        store_rep = store_data;
      end
    endcase
    byte_en = mask << off;
  end

  assign shifted  = load_raw >> {off, 3'b000};
  assign load_ext = extend_load(shifted, size_e'(size), load_unsigned);

endmodule

// File: rtl/mem_stage_lsu.sv
// DLX MEM stage: sized load/store with byte enables, misalignment squash and a
// wait-state FSM that stalls upstream until d_data_valid or a timeout abort.
module mem_stage_lsu
  import dlx_mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   alu_out_mem,
  input  logic [XLEN-1:0]   store_data_mem,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              load_en_mem,
  input  logic              store_en_mem,
  input  logic [1:0]        size_mem,
  input  logic              unsigned_mem,
  output logic [XLEN-1:0]   d_address,
  output logic [XLEN-1:0]   d_data_write,
  output logic [XLEN/8-1:0] d_byte_en,
  output logic              d_write_enable,
  output logic              d_read_enable,
  input  logic [XLEN-1:0]   d_data_read,
  input  logic              d_data_valid,
  output logic              stall,
  output logic              fwd_valid,
  output logic              fwd_is_load,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign,
  output logic              bus_error
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  mem_state_e      state_p0, state_next;
  logic [CW-1:0]   cnt_p0, cnt_next;
  logic            mem_op, aligned, req, done, timeout;
  logic [NB-1:0]   lane_en;
  logic [XLEN-1:0] store_rep, load_ext;

  assign mem_op  = in_valid & (load_en_mem | store_en_mem);
  assign aligned = is_aligned(size_e'(size_mem), alu_out_mem[2:0], XLEN == 64);
  // Reset drops the request so an aborted access cannot re-stall during reset.
  assign req     = reset_n & mem_op & aligned;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .off           (alu_out_mem[OW-1:0]),
    .size          (size_mem),
    .store_data    (store_data_mem),
    .load_raw      (d_data_read),
    .load_unsigned (unsigned_mem),
    .byte_en       (lane_en),
    .store_rep     (store_rep),
    .load_ext      (load_ext)
  );

  assign d_read_enable  = req & load_en_mem;
  assign d_write_enable = req & ~load_en_mem;
  assign d_address      = req ? {alu_out_mem[XLEN-1:OW], {OW{1'b0}}} : '0;
  assign d_data_write   = req ? store_rep : '0;
  assign d_byte_en      = req ? lane_en : '0;

  assign fwd_is_load = in_valid & load_en_mem;
  assign fwd_valid   = in_valid & ~load_en_mem & (rd_mem != '0) & ~store_en_mem;
  assign fwd_rd      = rd_mem;
  assign fwd_data    = alu_out_mem;

  always_comb begin
    state_next = state_p0;
    cnt_next   = cnt_p0;
    stall      = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state_p0)
      IDLE: begin
        if (req) begin
          if (d_data_valid) begin
            done = 1'b1;
          end else begin
            state_next = WAIT;
            stall      = 1'b1;
            cnt_next   = CW'(1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (d_data_valid) begin
          done       = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_p0 == MAX_CNT) begin
          timeout    = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_p0 + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // MEM/WB boundary
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_p0  <= IDLE;
      cnt_p0    <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state_p0  <= state_next;
      cnt_p0    <= cnt_next;
      wb_valid  <= 1'b0;
      misalign  <= 1'b0;
      bus_error <= timeout;
      if (in_valid && !mem_op) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_mem;
        wb_data  <= alu_out_mem;
      end else if (mem_op && !aligned) begin
        misalign <= 1'b1;
      end else if (done) begin
        wb_valid <= 1'b1;
        wb_rd    <= load_en_mem ? rd_mem : '0;
        wb_data  <= load_en_mem ? load_ext : alu_out_mem;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu: 32-bit instance for the main scenarios
// plus a 64-bit instance for doubleword access.
module tb_mem_stage_lsu;
  import dlx_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] alu_out_mem, store_data_mem, d_data_read;
  logic [4:0]  rd_mem;
  logic        load_en_mem, store_en_mem, unsigned_mem, d_data_valid;
  logic [1:0]  size_mem;
  logic [31:0] d_address, d_data_write, wb_data, fwd_data;
  logic [3:0]  d_byte_en;
  logic        d_write_enable, d_read_enable, stall, fwd_valid, fwd_is_load;
  logic [4:0]  fwd_rd, wb_rd;
  logic        wb_valid, misalign, bus_error;

  logic        in_valid64, load_en64, dv64;
  logic [1:0]  size64;
  logic [63:0] addr64, rdata64, d_address64, d_data_write64, fwd_data64, wb_data64;
  logic [7:0]  d_byte_en64;
  logic        we64, re64, stall64, fv64, fl64, wbv64, mis64, be64;
  logic [4:0]  fwd_rd64, wb_rd64;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .REG_AW(5), .MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .alu_out_mem(alu_out_mem),
    .store_data_mem(store_data_mem), .rd_mem(rd_mem), .load_en_mem(load_en_mem),
    .store_en_mem(store_en_mem), .size_mem(size_mem), .unsigned_mem(unsigned_mem),
    .d_address(d_address), .d_data_write(d_data_write), .d_byte_en(d_byte_en),
    .d_write_enable(d_write_enable), .d_read_enable(d_read_enable),
    .d_data_read(d_data_read), .d_data_valid(d_data_valid), .stall(stall),
    .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign),
    .bus_error(bus_error)
  );

  mem_stage_lsu #(.XLEN(64), .REG_AW(5), .MAX_WAIT(15)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid64), .alu_out_mem(addr64),
    .store_data_mem(64'h0), .rd_mem(5'd9), .load_en_mem(load_en64),
    .store_en_mem(1'b0), .size_mem(size64), .unsigned_mem(1'b0),
    .d_address(d_address64), .d_data_write(d_data_write64), .d_byte_en(d_byte_en64),
    .d_write_enable(we64), .d_read_enable(re64),
    .d_data_read(rdata64), .d_data_valid(dv64), .stall(stall64),
    .fwd_valid(fv64), .fwd_is_load(fl64), .fwd_rd(fwd_rd64), .fwd_data(fwd_data64),
    .wb_valid(wbv64), .wb_rd(wb_rd64), .wb_data(wb_data64), .misalign(mis64),
    .bus_error(be64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; load_en_mem = 1'b0; store_en_mem = 1'b0; size_mem = 2'd2;
    unsigned_mem = 1'b0; alu_out_mem = '0; store_data_mem = '0; rd_mem = '0;
    d_data_valid = 1'b0; d_data_read = '0;
  endtask

  task automatic op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    in_valid = 1'b1; load_en_mem = ld; store_en_mem = st; size_mem = sz;
    unsigned_mem = uns; alu_out_mem = addr; store_data_mem = sd; rd_mem = rd;
  endtask

  task automatic test_reset();
    idle();
    in_valid64 = 1'b0; load_en64 = 1'b0; size64 = 2'd3; addr64 = '0; rdata64 = '0; dv64 = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    total++; if ({wb_valid, misalign, bus_error, stall} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {wb_valid, misalign, bus_error, stall}); else passed++;
    total++; if ({wb_rd, wb_data} !== 37'h0) $display("FAIL reset_wb: rd %h data %h want 0", wb_rd, wb_data); else passed++;
    reset_n = 1'b1;
    tick();
    total++; if ({d_read_enable, d_write_enable, d_byte_en} !== 6'b0) $display("FAIL idle_req: got %b want 0", {d_read_enable, d_write_enable, d_byte_en}); else passed++;
  endtask

  task automatic test_word_load();
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5);
    d_data_valid = 1'b1; d_data_read = 32'hDEADBEEF;
    #1;
    total++; if ({stall, d_read_enable, d_write_enable} !== 3'b010) $display("FAIL wl_req: got %b want 010", {stall, d_read_enable, d_write_enable}); else passed++;
    total++; if (d_address !== 32'h100 || d_byte_en !== 4'hF) $display("FAIL wl_addr: got %h/%h want 100/f", d_address, d_byte_en); else passed++;
    total++; if (fwd_is_load !== 1'b1 || fwd_valid !== 1'b0) $display("FAIL wl_fwd: got %b%b want 10", fwd_is_load, fwd_valid); else passed++;
    tick(); idle();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_rd !== 5'd5) $display("FAIL wl_wb: got %b %h %h want 1 deadbeef 05", wb_valid, wb_data, wb_rd); else passed++;
  endtask

  task automatic test_byte_load(input logic uns, input logic [31:0] exp);
    op(1'b1, 1'b0, 2'd0, uns, 32'h103, 32'h0, 5'd6);
    d_data_read = 32'h80FFFFFF; d_data_valid = 1'b0;
    #1;
    total++; if (stall !== 1'b1 || d_read_enable !== 1'b1 || d_byte_en !== 4'b1000) $display("FAIL bl_w0: stall %b re %b be %b want 1 1 1000", stall, d_read_enable, d_byte_en); else passed++;
    tick();
    total++; if (stall !== 1'b1) $display("FAIL bl_w1: stall %b want 1", stall); else passed++;
    tick();
    d_data_valid = 1'b1;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL bl_done: stall %b want 0", stall); else passed++;
    tick(); idle();
    total++; if (wb_valid !== 1'b1 || wb_data !== exp) $display("FAIL bl_wb: got %b %h want 1 %h", wb_valid, wb_data, exp); else passed++;
  endtask

  task automatic test_half_store();
    op(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 5'd7);
    d_data_valid = 1'b1;
    #1;
    total++; if (d_byte_en !== 4'b1100 || d_data_write !== 32'hABCDABCD) $display("FAIL hs_lane: be %b data %h want 1100 abcdabcd", d_byte_en, d_data_write); else passed++;
    total++; if (d_address !== 32'h100 || d_write_enable !== 1'b1 || d_read_enable !== 1'b0 || fwd_valid !== 1'b0) $display("FAIL hs_req: addr %h we %b re %b fv %b", d_address, d_write_enable, d_read_enable, fwd_valid); else passed++;
    tick(); idle();
    total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0) $display("FAIL hs_wb: got %b %h want 1 00", wb_valid, wb_rd); else passed++;
  endtask

  task automatic test_misalign();
    op(1'b1, 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 5'd8);
    #1;
    total++; if (d_read_enable !== 1'b0 || stall !== 1'b0) $display("FAIL ma_req: re %b stall %b want 0 0", d_read_enable, stall); else passed++;
    tick(); idle();
    total++; if (misalign !== 1'b1 || wb_valid !== 1'b0) $display("FAIL ma_pulse: mis %b wbv %b want 1 0", misalign, wb_valid); else passed++;
    tick();
    total++; if (misalign !== 1'b0) $display("FAIL ma_once: mis %b want 0", misalign); else passed++;
    op(1'b1, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 5'd8);
    #1;
    total++; if (d_read_enable !== 1'b0) $display("FAIL ma_d32: re %b want 0", d_read_enable); else passed++;
    tick(); idle();
    total++; if (misalign !== 1'b1) $display("FAIL ma_d32_pulse: mis %b want 1", misalign); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    bit ended;
    n = 0; ended = 1'b0;
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd4);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) begin ended = 1'b1; break; end
      n++;
      tick();
    end
    total++; if (!ended || n != 15) $display("FAIL to_stall: ended %b cycles %0d want 1 15", ended, n); else passed++;
    tick(); idle();
    total++; if (bus_error !== 1'b1 || wb_valid !== 1'b0) $display("FAIL to_berr: be %b wbv %b want 1 0", bus_error, wb_valid); else passed++;
    op(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 5'd3);
    d_data_valid = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || fwd_valid !== 1'b1 || fwd_data !== 32'h1234 || d_read_enable !== 1'b0) $display("FAIL alu_comb: stall %b fv %b fd %h re %b", stall, fwd_valid, fwd_data, d_read_enable); else passed++;
    tick(); idle();
    total++; if (bus_error !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'h1234 || wb_rd !== 5'd3) $display("FAIL alu_wb: be %b wbv %b data %h rd %h want 0 1 1234 03", bus_error, wb_valid, wb_data, wb_rd); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd2);
    tick(); tick(); tick();
    #1;
    total++; if (stall !== 1'b1) $display("FAIL rw_pre: stall %b want 1", stall); else passed++;
    reset_n = 1'b0; in_valid = 1'b0;
    tick();
    total++; if (stall !== 1'b0 || wb_valid !== 1'b0 || bus_error !== 1'b0) $display("FAIL rw_abort: stall %b wbv %b be %b want 000", stall, wb_valid, bus_error); else passed++;
    reset_n = 1'b1;
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd2);
    d_data_valid = 1'b1; d_data_read = 32'h0BADF00D;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL rw_idle: stall %b want 0", stall); else passed++;
    tick(); idle();
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h0BADF00D) $display("FAIL rw_wb: got %b %h want 1 0badf00d", wb_valid, wb_data); else passed++;
  endtask

  task automatic test_double64();
    in_valid64 = 1'b1; load_en64 = 1'b1; size64 = 2'd3; addr64 = 64'h8;
    dv64 = 1'b1; rdata64 = 64'h0123456789ABCDEF;
    #1;
    total++; if (d_byte_en64 !== 8'hFF || re64 !== 1'b1 || d_address64 !== 64'h8 || stall64 !== 1'b0) $display("FAIL d64_req: be %h re %b addr %h stall %b", d_byte_en64, re64, d_address64, stall64); else passed++;
    tick();
    in_valid64 = 1'b0; load_en64 = 1'b0; dv64 = 1'b0;
    total++; if (wbv64 !== 1'b1 || wb_data64 !== 64'h0123456789ABCDEF) $display("FAIL d64_wb: got %b %h want 1 0123456789abcdef", wbv64, wb_data64); else passed++;
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load(1'b0, 32'hFFFFFF80);
    test_byte_load(1'b1, 32'h00000080);
    test_half_store();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    test_double64();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
